nanorv32_mem_arbiter: RTL and testbench

Two-port to one-port arbiter sharing a single synchronous SRAM (1-cycle read latency) between the nanorv32 instruction-fetch port and data port. Sits between `nanorv32_simple` core ports and a unified code/data RAM in single-memory chip variants. Sequences each access with a grant/response state machine and returns per-requester ready strobes.

---
 rtl/nanorv32_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_nanorv32_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// nanorv32_mem_arbiter
//
// Shares one synchronous single-port SRAM (one-cycle read latency) between the
// nanorv32 instruction-fetch port and data port. Every access takes an issue
// cycle, in which the RAM strobe, address, write data and byte enables are
// driven, followed by a response cycle, in which the requester's ready strobe
// is raised while the RAM read data is on the bus. The response of one access
// overlaps the issue of the next one, so two active requesters alternate at
// full RAM bandwidth.
//
// Configuration macro:
//   NANORV32_ARB_ROUND_ROBIN_EN
//     defined   : a tie goes to the requester that did not win last time.
//                 The first tie after reset goes to the fetch port.
//     undefined : fixed priority, where the data port wins every tie. The
//                 fetch port still makes progress because the data port cannot
//                 win the cycle in which its own ready is returned.
//
// Parameters:
//   ADDR_W  word address width of the shared RAM
//   DATA_W  data width (32 for nanorv32)
//
// Ports:
//   clk, rst_n           core clock; asynchronous active-low reset
//   cpu_codemem_*        fetch request (valid, word address)
//   codemem_cpu_*        fetch response (ready strobe, read data)
//   cpu_datamem_*        data request (valid, address, write, bytesel, wdata)
//   datamem_cpu_*        data response (ready strobe, read data)
//   mem_en/we/addr/wdata RAM command, combinational from state and requests
//   mem_rdata            RAM read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module nanorv32_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              cpu_codemem_valid,
   input  logic [ADDR_W-1:0] cpu_codemem_addr,
   output logic              codemem_cpu_ready,
   output logic [DATA_W-1:0] codemem_cpu_rdata,

   input  logic              cpu_datamem_valid,
   input  logic [ADDR_W-1:0] cpu_datamem_addr,
   input  logic              cpu_datamem_write,
   input  logic [3:0]        cpu_datamem_bytesel,
   input  logic [DATA_W-1:0] cpu_datamem_wdata,
   output logic              datamem_cpu_ready,
   output logic [DATA_W-1:0] datamem_cpu_rdata,

   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_CODE = 2'd1,
      GNT_DATA = 2'd2
   } state_t;

   localparam logic GRANT_CODE = 1'b0;
   localparam logic GRANT_DATA = 1'b1;

   state_t state;
   logic   last_grant;
   logic   code_ready_q;
   logic   data_ready_q;

   logic   code_eligible;
   logic   data_eligible;
   logic   issue;
   logic   pick_data;

   // A requester whose ready is being returned this cycle still holds its
   // valid high, so it is masked out of arbitration for that one cycle.
   // Without the mask the same request would be issued a second time.
   always_comb begin
      code_eligible = cpu_codemem_valid && (state != GNT_CODE);
      data_eligible = cpu_datamem_valid && (state != GNT_DATA);
      issue         = code_eligible || data_eligible;
   end

`ifdef NANORV32_ARB_ROUND_ROBIN_EN
   // Round-robin tie break: when both ports are eligible, the port that did
   // not win the previous issue gets the RAM. last_grant resets to DATA, so
   // the first tie after reset goes to the fetch port.
   always_comb begin
      if (code_eligible && data_eligible) begin
         pick_data = (last_grant == GRANT_CODE);
      end else begin
         pick_data = data_eligible;
      end
   end
`else
   // Fixed priority: the data port wins any tie. last_grant is still kept
   // up to date so both builds have the same register set, but it does not
   // steer arbitration here.
   always_comb begin
      pick_data = data_eligible;
   end

   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // RAM command for the issue cycle. The strobe and byte enables are gated
   // with rst_n so that a reset never lets a stray access or write reach the
   // RAM. The fetch port never writes, so its write data is zero.
   always_comb begin
      mem_en    = issue && rst_n;
      mem_we    = 4'b0000;
      mem_addr  = cpu_codemem_addr;
      mem_wdata = '0;
      if (pick_data) begin
         mem_addr  = cpu_datamem_addr;
         mem_wdata = cpu_datamem_wdata;
      end
      if (issue && rst_n && pick_data && cpu_datamem_write) begin
         mem_we = cpu_datamem_bytesel;
      end
   end

   // Grant state machine. Every issue moves to the winner's grant state and
   // records the winner. With nothing to issue, the machine falls back to
   // IDLE. The ready strobes are registered alongside the state, so each one
   // is high exactly during the response cycle that follows its issue. An
   // asynchronous reset drops any access in flight, and no ready is returned
   // for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= GRANT_DATA;
         code_ready_q <= 1'b0;
         data_ready_q <= 1'b0;
      end else begin
         code_ready_q <= issue && !pick_data;
         data_ready_q <= issue && pick_data;
         if (issue) begin
            state      <= pick_data ? GNT_DATA : GNT_CODE;
            last_grant <= pick_data ? GRANT_DATA : GRANT_CODE;
         end else begin
            state      <= IDLE;
         end
      end
   end

   // Both read-data outputs are plain copies of the RAM output. Only the
   // matching ready strobe tells a requester that the data is meant for it.
   always_comb begin
      codemem_cpu_ready = code_ready_q;
      datamem_cpu_ready = data_ready_q;
      codemem_cpu_rdata = mem_rdata;
      datamem_cpu_rdata = mem_rdata;
   end

endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_mem_arbiter
//
// Testbench for nanorv32_mem_arbiter. It contains:
//   - a behavioural byte-enabled SRAM with one-cycle read latency, connected
//     to the arbiter's RAM port;
//   - a table of per-cycle vectors covering a single fetch, a byte-masked
//     write followed by a read of the same word, and response/issue overlap;
//   - hand-written sequences for reset, reset in the middle of an access, and
//     two requesters contending continuously;
//   - randomized requests checked against a transaction-level reference model
//     that works from the arbitration rules and a shadow copy of memory.
// The expected results for contention follow NANORV32_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_nanorv32_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

`ifdef NANORV32_ARB_ROUND_ROBIN_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_codemem_valid;
   logic [ADDR_W-1:0] cpu_codemem_addr;
   logic              codemem_cpu_ready;
   logic [DATA_W-1:0] codemem_cpu_rdata;
   logic              cpu_datamem_valid;
   logic [ADDR_W-1:0] cpu_datamem_addr;
   logic              cpu_datamem_write;
   logic [3:0]        cpu_datamem_bytesel;
   logic [DATA_W-1:0] cpu_datamem_wdata;
   logic              datamem_cpu_ready;
   logic [DATA_W-1:0] datamem_cpu_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   nanorv32_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cpu_codemem_valid   (cpu_codemem_valid),
      .cpu_codemem_addr    (cpu_codemem_addr),
      .codemem_cpu_ready   (codemem_cpu_ready),
      .codemem_cpu_rdata   (codemem_cpu_rdata),
      .cpu_datamem_valid   (cpu_datamem_valid),
      .cpu_datamem_addr    (cpu_datamem_addr),
      .cpu_datamem_write   (cpu_datamem_write),
      .cpu_datamem_bytesel (cpu_datamem_bytesel),
      .cpu_datamem_wdata   (cpu_datamem_wdata),
      .datamem_cpu_ready   (datamem_cpu_ready),
      .datamem_cpu_rdata   (datamem_cpu_rdata),
      .mem_en              (mem_en),
      .mem_we              (mem_we),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_rdata           (mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM. Reads return the old word one cycle after mem_en, and
   // writes update only the bytes whose enables are set.
   logic [31:0] sramArr [0:65535];
   logic [31:0] refMem  [0:65535];

   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= sramArr[mem_addr];
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) sramArr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   function automatic logic [31:0] pat(input logic [15:0] a);
      return {a ^ 16'hC0DE, a};
   endfunction

   int errCount   = 0;
   int checkCount = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic driveInputs(input logic cv, input logic [15:0] ca,
                              input logic dv, input logic [15:0] da,
                              input logic dw, input logic [3:0] bs,
                              input logic [31:0] wd);
      cpu_codemem_valid   = cv;
      cpu_codemem_addr    = ca;
      cpu_datamem_valid   = dv;
      cpu_datamem_addr    = da;
      cpu_datamem_write   = dw;
      cpu_datamem_bytesel = bs;
      cpu_datamem_wdata   = wd;
   endtask

   // One table row covers one clock cycle. Inputs are driven just after the
   // rising edge, and the expected outputs are checked on the falling edge.
   typedef struct {
      logic        cv;
      logic [15:0] caddr;
      logic        dv;
      logic [15:0] daddr;
      logic        dwr;
      logic [3:0]  dbsel;
      logic [31:0] dwdata;
      logic        expEn;
      logic [3:0]  expWe;
      logic [15:0] expAddr;
      logic        expCr;
      logic        expDr;
      logic        chkCdata;
      logic [31:0] expCdata;
      logic        chkDdata;
      logic [31:0] expDdata;
   } vec_t;

   vec_t vecs [12];

   task automatic applyStimulus(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      driveInputs(v.cv, v.caddr, v.dv, v.daddr, v.dwr, v.dbsel, v.dwdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d mem_en", idx), 64'(mem_en), 64'(v.expEn));
      checkOutput($sformatf("vec%0d mem_we", idx), 64'(mem_we), 64'(v.expWe));
      checkOutput($sformatf("vec%0d code_ready", idx), 64'(codemem_cpu_ready), 64'(v.expCr));
      checkOutput($sformatf("vec%0d data_ready", idx), 64'(datamem_cpu_ready), 64'(v.expDr));
      if (v.expEn)
         checkOutput($sformatf("vec%0d mem_addr", idx), 64'(mem_addr), 64'(v.expAddr));
      if (v.expWe != 4'b0000)
         checkOutput($sformatf("vec%0d mem_wdata", idx), 64'(mem_wdata), 64'(v.dwdata));
      if (v.chkCdata)
         checkOutput($sformatf("vec%0d code_rdata", idx), 64'(codemem_cpu_rdata), 64'(v.expCdata));
      if (v.chkDdata)
         checkOutput($sformatf("vec%0d data_rdata", idx), 64'(datamem_cpu_rdata), 64'(v.expDdata));
   endtask

   // Reference-model state: the requests outstanding at each port, the
   // responses owed (one per issued access, due the following cycle), and
   // which port won the most recent issue (0 = code, 1 = data).
   typedef struct {
      int          who;
      bit          isRead;
      logic [31:0] data;
   } resp_t;

   resp_t       respQ [$];
   int          lastWin;
   bit          actC, actD;
   logic [15:0] aC, aD;
   logic        wD;
   logic [3:0]  bD;
   logic [31:0] wdD;

   task automatic doReset();
      rst_n = 1'b0;
      driveInputs(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      respQ.delete();
      lastWin = 1;
      actC    = 1'b0;
      actD    = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0,
                   1'b1, 4'h0, 16'h0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0,
                   1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h00000013, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0,
                   1'b1, 4'h0, 16'h0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0,
                   1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h00000013, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 4'b0011, 32'hAABBCCDD,
                   1'b1, 4'b0011, 16'h0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 4'b0011, 32'hAABBCCDD,
                   1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 4'h0, 32'h0,
                   1'b1, 4'h0, 16'h0100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 4'h0, 32'h0,
                   1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1122CCDD};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 4'h0, 32'h0,
                   1'b1, 4'h0, 16'h0030, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 16'h0020, 1'b1, 16'h0030, 1'b0, 4'h0, 32'h0,
                   1'b1, 4'h0, 16'h0020, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, pat(16'h0030)};
      vecs[10] = '{1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0,
                   1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, pat(16'h0020), 1'b0, 32'h0};
      vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 32'h0,
                   1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

      for (int i = 0; i < 65536; i++) sramArr[i] <= pat(16'(i));
      sramArr[16'h0010] <= 32'h00000013;
      sramArr[16'h0100] <= 32'h11223344;

      // Reset held with both ports requesting: nothing may reach the RAM.
      rst_n = 1'b0;
      driveInputs(1'b1, 16'h0040, 1'b1, 16'h0200, 1'b1, 4'hF, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst mem_en", 64'(mem_en), 64'd0);
      checkOutput("rst mem_we", 64'(mem_we), 64'd0);
      checkOutput("rst code_ready", 64'(codemem_cpu_ready), 64'd0);
      checkOutput("rst data_ready", 64'(datamem_cpu_ready), 64'd0);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("release mem_en", 64'(mem_en), 64'd1);
      checkOutput("release mem_addr", 64'(mem_addr), RR_MODE ? 64'h40 : 64'h200);
      @(negedge clk);
      checkOutput("first code_ready", 64'(codemem_cpu_ready), RR_MODE ? 64'd1 : 64'd0);
      checkOutput("first data_ready", 64'(datamem_cpu_ready), RR_MODE ? 64'd0 : 64'd1);

      // Directed table: fetch, byte-masked write and read-back, overlap.
      doReset();
      for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

      // Reset in the response cycle of a data read drops that response.
      @(posedge clk);
      #1 driveInputs(1'b0, 16'h0, 1'b1, 16'h0030, 1'b0, 4'h0, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst data_ready", 64'(datamem_cpu_ready), 64'd0);
      checkOutput("midrst mem_en", 64'(mem_en), 64'd0);
      #2 rst_n = 1'b1;
      #1;
      checkOutput("midrst idle mem_en", 64'(mem_en), 64'd1);
      checkOutput("midrst idle mem_addr", 64'(mem_addr), 64'h30);
      checkOutput("midrst idle data_ready", 64'(datamem_cpu_ready), 64'd0);
      @(negedge clk);
      checkOutput("midrst retry data_ready", 64'(datamem_cpu_ready), 64'd1);
      checkOutput("midrst retry rdata", 64'(datamem_cpu_rdata), 64'(pat(16'h0030)));

      // Continuous contention from IDLE: strict alternation in the order set
      // by the tie-break policy, with each ready one cycle after its issue.
      doReset();
      @(posedge clk);
      #1 driveInputs(1'b1, 16'h0050, 1'b1, 16'h0060, 1'b0, 4'h0, 32'h0);
      for (int k = 0; k < 6; k++) begin
         bit winData, prevData;
         @(negedge clk);
         winData  = RR_MODE ? (k % 2 == 1) : (k % 2 == 0);
         prevData = RR_MODE ? (k % 2 == 0) : (k % 2 == 1);
         checkOutput($sformatf("cont%0d mem_en", k), 64'(mem_en), 64'd1);
         checkOutput($sformatf("cont%0d mem_addr", k), 64'(mem_addr), winData ? 64'h60 : 64'h50);
         checkOutput($sformatf("cont%0d code_ready", k), 64'(codemem_cpu_ready),
                     64'((k > 0) && !prevData));
         checkOutput($sformatf("cont%0d data_ready", k), 64'(datamem_cpu_ready),
                     64'((k > 0) && prevData));
         if (k > 0 && prevData)
            checkOutput($sformatf("cont%0d data_rdata", k), 64'(datamem_cpu_rdata), 64'(pat(16'h0060)));
         if (k > 0 && !prevData)
            checkOutput($sformatf("cont%0d code_rdata", k), 64'(codemem_cpu_rdata), 64'(pat(16'h0050)));
      end

      // Randomized traffic against the transaction-level model.
      doReset();
      refMem = sramArr;
      for (int cyc = 0; cyc < 400; cyc++) begin
         resp_t r;
         bit    codeE, dataE;
         int    win;
         @(posedge clk);
         #1;
         if (!actC && $urandom_range(0, 99) < 60) begin
            actC = 1'b1;
            aC   = 16'($urandom_range(0, 31));
         end
         if (!actD && $urandom_range(0, 99) < 60) begin
            actD = 1'b1;
            aD   = 16'($urandom_range(0, 31));
            wD   = 1'($urandom_range(0, 1));
            bD   = 4'($urandom_range(0, 15));
            wdD  = $urandom;
         end
         driveInputs(actC, aC, actD, aD, wD, bD, wdD);
         @(negedge clk);

         r.who    = -1;
         r.isRead = 1'b0;
         r.data   = 32'h0;
         if (respQ.size() > 0) r = respQ.pop_front();
         checkOutput("rnd code_ready", 64'(codemem_cpu_ready), 64'(r.who == 0));
         checkOutput("rnd data_ready", 64'(datamem_cpu_ready), 64'(r.who == 1));
         if (r.who == 0 && r.isRead)
            checkOutput("rnd code_rdata", 64'(codemem_cpu_rdata), 64'(r.data));
         if (r.who == 1 && r.isRead)
            checkOutput("rnd data_rdata", 64'(datamem_cpu_rdata), 64'(r.data));

         codeE = actC && (r.who != 0);
         dataE = actD && (r.who != 1);
         if (codeE && dataE) win = RR_MODE ? ((lastWin == 1) ? 0 : 1) : 1;
         else if (codeE)     win = 0;
         else if (dataE)     win = 1;
         else                win = -1;

         checkOutput("rnd mem_en", 64'(mem_en), 64'(win >= 0));
         checkOutput("rnd mem_we", 64'(mem_we), 64'((win == 1 && wD) ? bD : 4'h0));
         if (win >= 0) begin
            resp_t n;
            logic [15:0] a;
            a = (win == 1) ? aD : aC;
            checkOutput("rnd mem_addr", 64'(mem_addr), 64'(a));
            n.who    = win;
            n.isRead = !(win == 1 && wD);
            n.data   = refMem[a];
            if (win == 1 && wD) begin
               checkOutput("rnd mem_wdata", 64'(mem_wdata), 64'(wdD));
               for (int b = 0; b < 4; b++)
                  if (bD[b]) refMem[a][8*b +: 8] = wdD[8*b +: 8];
            end
            respQ.push_back(n);
            lastWin = win;
         end
         if (r.who == 0) actC = 1'b0;
         if (r.who == 1) actD = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
